// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with interrupt trap entry and mret return sequencing
//   clk_o, reset                      : clock (rising edge), synchronous active-high reset
//   csr_addr, csr_op, csr_rd, csr_wdata : CSR access from MW (op 00 none, 01 write, 10 set, 11 clear)
//   csr_rdata, csr_illegal            : combinational read data, unimplemented-address flag
//   pc_in, is_mret                    : PC of the MW instruction, MW holds mret
//   irq_in                            : level interrupt requests, line i -> mie/mip bit i
//   trap_take, epc_valid, epc         : one-cycle flush/redirect outputs decoded from state
module csr_trap_unit #(
    parameter int XLEN       = 32,
    parameter int NUM_IRQ    = 2,
    parameter int CAUSE_BASE = 16
) (
    input  logic               clk_o,
    input  logic               reset,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic               csr_rd,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               csr_illegal,
    input  logic [XLEN-1:0]    pc_in,
    input  logic               is_mret,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               trap_take,
    output logic               epc_valid,
    output logic [XLEN-1:0]    epc
);
    typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;
    state_t state, state_next;
    logic ms_mie, ms_mpie, impl, take, wr;
    logic [NUM_IRQ-1:0] mie, mip, pending;
    logic [XLEN-1:0] mcause, mepc, mtvec, cur, nv, target;
    logic [4:0] idx;
    logic [XLEN-2:0] code;
    always_comb begin
        impl = 1'b1;
        cur = '0;
        case (csr_addr)
            12'h300: begin
                cur[3] = ms_mie;
                cur[7] = ms_mpie;
            end
            12'h304: cur[NUM_IRQ-1:0] = mie;
            12'h344: cur[NUM_IRQ-1:0] = mip;
            12'h342: cur = mcause;
            12'h341: cur = mepc;
            12'h305: cur = mtvec;
            default: impl = 1'b0;
        endcase
    end
    always_comb begin
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pending[i]) idx = 5'(i);
    end
    assign pending     = mip & mie;
    assign take        = (state == IDLE) && ms_mie && |pending;
    assign code        = (XLEN-1)'(CAUSE_BASE) + (XLEN-1)'(idx);
    assign nv          = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? cur | csr_wdata : cur & ~csr_wdata;
    // a trap squashes the MW instruction, so its CSR write must not land
    assign wr          = (state == IDLE) && !take && csr_op != 2'b00 && impl;
    assign csr_rdata   = csr_rd ? cur : '0;
    assign csr_illegal = (csr_rd || csr_op != 2'b00) && !impl;
    // code<<2 drops the interrupt flag in mcause's top bit
    assign target      = {mtvec[XLEN-1:2], 2'b00} + (mtvec[1:0] == 2'b01 ? {mcause[XLEN-3:0], 2'b00} : '0);
    assign trap_take   = state == TRAP;
    assign epc_valid   = state != IDLE;
    assign epc         = state == TRAP ? target : state == RET ? mepc : '0;
    always_comb begin
        state_next = state != IDLE ? IDLE : take ? TRAP : is_mret ? RET : IDLE;
    end
    always_ff @(posedge clk_o) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge clk_o) begin
        if (reset) begin
            ms_mie  <= 1'b0;
            ms_mpie <= 1'b0;
            mie     <= '0;
            mip     <= '0;
            mcause  <= '0;
            mepc    <= '0;
            mtvec   <= '0;
        end else begin
            mip <= irq_in;
            if (wr)
                case (csr_addr)
                    12'h300: begin
                        ms_mie  <= nv[3];
                        ms_mpie <= nv[7];
                    end
                    12'h304: mie <= nv[NUM_IRQ-1:0];
                    12'h342: mcause <= nv;
                    12'h341: mepc <= {nv[XLEN-1:2], 2'b00};
                    12'h305: mtvec <= {nv[XLEN-1:2], nv[1] ? mtvec[1:0] : nv[1:0]};
                    default: ;
                endcase
            if (take) begin
                mepc    <= pc_in & {{(XLEN-2){1'b1}}, 2'b00};
                mcause  <= {1'b1, code};
                ms_mpie <= ms_mie;
                ms_mie  <= 1'b0;
            end else if (state == IDLE && is_mret) begin
                ms_mie  <= ms_mpie;
                ms_mpie <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed self-checking bench for csr_trap_unit
module tb_csr_trap_unit;
    logic        clk_o = 1'b0, reset = 1'b1, csr_rd = 1'b0, is_mret = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0, irq_in = '0;
    logic [31:0] csr_wdata = '0, pc_in = '0, csr_rdata, epc, d;
    logic        csr_illegal, trap_take, epc_valid;
    int cmp = 0, err = 0;

    csr_trap_unit dut (
        .clk_o(clk_o), .reset(reset), .csr_addr(csr_addr), .csr_op(csr_op), .csr_rd(csr_rd),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .pc_in(pc_in),
        .is_mret(is_mret), .irq_in(irq_in), .trap_take(trap_take), .epc_valid(epc_valid), .epc(epc)
    );

    always #5 clk_o = ~clk_o;

    task automatic tick();
        @(posedge clk_o);
        #1;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] v);
        csr_addr = a;
        csr_rd = 1'b1;
        #1;
        v = csr_rdata;
        csr_rd = 1'b0;
    endtask

    task automatic csr_access(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
        csr_op = op;
        csr_addr = a;
        csr_wdata = w;
        tick();
        csr_op = 2'b00;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [6] = '{12'h300, 12'h304, 12'h344, 12'h342, 12'h341, 12'h305};
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cmp++; if (trap_take !== 1'b0) begin err++; $display("FAIL reset_trap_take got %b want 0", trap_take); end
        cmp++; if (epc_valid !== 1'b0) begin err++; $display("FAIL reset_epc_valid got %b want 0", epc_valid); end
        cmp++; if (epc !== 32'h0) begin err++; $display("FAIL reset_epc got %h want 0", epc); end
        foreach (addrs[i]) begin
            csr_read(addrs[i], d);
            cmp++; if (d !== 32'h0) begin err++; $display("FAIL reset_csr_%h got %h want 0", addrs[i], d); end
        end
        csr_addr = 12'h7C0;
        csr_rd = 1'b1;
        #1;
        cmp++; if (csr_illegal !== 1'b1) begin err++; $display("FAIL illegal_7c0 got %b want 1", csr_illegal); end
        cmp++; if (csr_rdata !== 32'h0) begin err++; $display("FAIL illegal_rdata got %h want 0", csr_rdata); end
        csr_rd = 1'b0;
        #1;
        cmp++; if (csr_illegal !== 1'b0) begin err++; $display("FAIL illegal_idle got %b want 0", csr_illegal); end
    endtask

    task automatic test_csr_fields();
        csr_access(2'b01, 12'h341, 32'h123);
        csr_read(12'h341, d);
        cmp++; if (d !== 32'h120) begin err++; $display("FAIL mepc_align got %h want 120", d); end
        csr_access(2'b01, 12'h342, 32'hDEADBEEF);
        csr_read(12'h342, d);
        cmp++; if (d !== 32'hDEADBEEF) begin err++; $display("FAIL mcause_rw got %h want deadbeef", d); end
        csr_op = 2'b01;
        csr_addr = 12'h344;
        csr_wdata = 32'hFF;
        #1;
        cmp++; if (csr_illegal !== 1'b0) begin err++; $display("FAIL mip_write_legal got %b want 0", csr_illegal); end
        tick();
        csr_op = 2'b00;
        csr_read(12'h344, d);
        cmp++; if (d !== 32'h0) begin err++; $display("FAIL mip_readonly got %h want 0", d); end
        csr_access(2'b01, 12'h300, 32'hFFFF_FFFF);
        csr_read(12'h300, d);
        cmp++; if (d !== 32'h88) begin err++; $display("FAIL mstatus_fields got %h want 88", d); end
        csr_access(2'b01, 12'h300, 32'h0);
    endtask

    task automatic test_trap_direct();
        csr_access(2'b01, 12'h305, 32'h100);
        csr_access(2'b01, 12'h304, 32'h2);
        csr_access(2'b10, 12'h300, 32'h8);
        csr_read(12'h300, d);
        cmp++; if (d !== 32'h8) begin err++; $display("FAIL mstatus_set got %h want 8", d); end
        pc_in = 32'h40;
        irq_in = 2'b10;
        tick();
        cmp++; if (trap_take !== 1'b0) begin err++; $display("FAIL direct_early got %b want 0", trap_take); end
        csr_op = 2'b01;
        csr_addr = 12'h305;
        csr_wdata = 32'h200;
        tick();
        csr_op = 2'b00;
        cmp++; if (trap_take !== 1'b1) begin err++; $display("FAIL direct_take got %b want 1", trap_take); end
        cmp++; if (epc_valid !== 1'b1) begin err++; $display("FAIL direct_valid got %b want 1", epc_valid); end
        cmp++; if (epc !== 32'h100) begin err++; $display("FAIL direct_epc got %h want 100", epc); end
        irq_in = 2'b00;
        tick();
        cmp++; if (trap_take !== 1'b0 || epc_valid !== 1'b0) begin err++; $display("FAIL direct_one_cycle got %b%b want 00", trap_take, epc_valid); end
        cmp++; if (epc !== 32'h0) begin err++; $display("FAIL direct_epc_idle got %h want 0", epc); end
        csr_read(12'h305, d);
        cmp++; if (d !== 32'h100) begin err++; $display("FAIL dropped_write got %h want 100", d); end
        csr_read(12'h341, d);
        cmp++; if (d !== 32'h40) begin err++; $display("FAIL direct_mepc got %h want 40", d); end
        csr_read(12'h342, d);
        cmp++; if (d !== 32'h80000011) begin err++; $display("FAIL direct_mcause got %h want 80000011", d); end
        csr_read(12'h300, d);
        cmp++; if (d !== 32'h80) begin err++; $display("FAIL direct_mstatus got %h want 80", d); end
    endtask

    task automatic test_mret();
        pc_in = 32'h50;
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        cmp++; if (epc_valid !== 1'b1) begin err++; $display("FAIL mret_valid got %b want 1", epc_valid); end
        cmp++; if (trap_take !== 1'b0) begin err++; $display("FAIL mret_take got %b want 0", trap_take); end
        cmp++; if (epc !== 32'h40) begin err++; $display("FAIL mret_epc got %h want 40", epc); end
        tick();
        cmp++; if (epc_valid !== 1'b0) begin err++; $display("FAIL mret_one_cycle got %b want 0", epc_valid); end
        csr_read(12'h300, d);
        cmp++; if (d !== 32'h88) begin err++; $display("FAIL mret_mstatus got %h want 88", d); end
    endtask

    task automatic test_trap_vectored();
        csr_access(2'b01, 12'h305, 32'h101);
        pc_in = 32'h80;
        irq_in = 2'b10;
        tick();
        tick();
        cmp++; if (trap_take !== 1'b1) begin err++; $display("FAIL vec_take got %b want 1", trap_take); end
        cmp++; if (epc !== 32'h144) begin err++; $display("FAIL vec_epc got %h want 144", epc); end
        irq_in = 2'b00;
        tick();
        csr_read(12'h341, d);
        cmp++; if (d !== 32'h80) begin err++; $display("FAIL vec_mepc got %h want 80", d); end
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        cmp++; if (epc !== 32'h80) begin err++; $display("FAIL vec_ret_epc got %h want 80", epc); end
        tick();
    endtask

    task automatic test_priority();
        csr_access(2'b10, 12'h304, 32'h1);
        csr_read(12'h304, d);
        cmp++; if (d !== 32'h3) begin err++; $display("FAIL mie_set got %h want 3", d); end
        csr_access(2'b11, 12'h304, 32'h2);
        csr_read(12'h304, d);
        cmp++; if (d !== 32'h1) begin err++; $display("FAIL mie_clear got %h want 1", d); end
        csr_access(2'b10, 12'h304, 32'h2);
        csr_access(2'b01, 12'h304, 32'hFFFF);
        csr_read(12'h304, d);
        cmp++; if (d !== 32'h3) begin err++; $display("FAIL mie_width got %h want 3", d); end
        csr_access(2'b01, 12'h305, 32'h203);
        csr_read(12'h305, d);
        cmp++; if (d !== 32'h201) begin err++; $display("FAIL mtvec_mode3 got %h want 201", d); end
        csr_access(2'b01, 12'h305, 32'h302);
        csr_read(12'h305, d);
        cmp++; if (d !== 32'h301) begin err++; $display("FAIL mtvec_mode2 got %h want 301", d); end
        csr_access(2'b01, 12'h305, 32'h200);
        csr_read(12'h305, d);
        cmp++; if (d !== 32'h200) begin err++; $display("FAIL mtvec_mode0 got %h want 200", d); end
        csr_access(2'b01, 12'h305, 32'h201);
        pc_in = 32'h90;
        irq_in = 2'b11;
        tick();
        tick();
        cmp++; if (trap_take !== 1'b1) begin err++; $display("FAIL prio_take got %b want 1", trap_take); end
        cmp++; if (epc !== 32'h240) begin err++; $display("FAIL prio_epc got %h want 240", epc); end
        irq_in = 2'b00;
        tick();
        csr_read(12'h342, d);
        cmp++; if (d !== 32'h80000010) begin err++; $display("FAIL prio_mcause got %h want 80000010", d); end
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        tick();
    endtask

    task automatic test_mret_irq();
        irq_in = 2'b01;
        tick();
        is_mret = 1'b1;
        pc_in = 32'h300;
        tick();
        is_mret = 1'b0;
        irq_in = 2'b00;
        cmp++; if (trap_take !== 1'b1) begin err++; $display("FAIL mret_irq_take got %b want 1", trap_take); end
        cmp++; if (epc !== 32'h240) begin err++; $display("FAIL mret_irq_epc got %h want 240", epc); end
        tick();
        csr_read(12'h341, d);
        cmp++; if (d !== 32'h300) begin err++; $display("FAIL mret_irq_mepc got %h want 300", d); end
        csr_read(12'h300, d);
        cmp++; if (d !== 32'h80) begin err++; $display("FAIL mret_irq_mstatus got %h want 80", d); end
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        cmp++; if (epc !== 32'h300) begin err++; $display("FAIL mret_irq_ret got %h want 300", epc); end
        tick();
    endtask

    task automatic test_masked_pending();
        csr_access(2'b11, 12'h300, 32'h8);
        csr_read(12'h300, d);
        cmp++; if (d !== 32'h80) begin err++; $display("FAIL mask_mstatus got %h want 80", d); end
        irq_in = 2'b10;
        tick();
        tick();
        cmp++; if (trap_take !== 1'b0) begin err++; $display("FAIL mask_no_take got %b want 0", trap_take); end
        csr_read(12'h344, d);
        cmp++; if (d !== 32'h2) begin err++; $display("FAIL mask_mip got %h want 2", d); end
        csr_access(2'b10, 12'h300, 32'h8);
        cmp++; if (trap_take !== 1'b0) begin err++; $display("FAIL mask_enable_cycle got %b want 0", trap_take); end
        tick();
        cmp++; if (trap_take !== 1'b1) begin err++; $display("FAIL mask_take got %b want 1", trap_take); end
        cmp++; if (epc !== 32'h244) begin err++; $display("FAIL mask_epc got %h want 244", epc); end
        irq_in = 2'b00;
        tick();
    endtask

    task automatic test_reset_in_trap();
        csr_access(2'b10, 12'h300, 32'h8);
        irq_in = 2'b01;
        tick();
        tick();
        cmp++; if (trap_take !== 1'b1) begin err++; $display("FAIL rst_trap_take got %b want 1", trap_take); end
        reset = 1'b1;
        irq_in = 2'b00;
        tick();
        cmp++; if (trap_take !== 1'b0 || epc_valid !== 1'b0 || epc !== 32'h0) begin err++; $display("FAIL rst_in_trap got %b %b %h want 0 0 0", trap_take, epc_valid, epc); end
        reset = 1'b0;
        tick();
        cmp++; if (trap_take !== 1'b0 || epc_valid !== 1'b0 || epc !== 32'h0) begin err++; $display("FAIL rst_after got %b %b %h want 0 0 0", trap_take, epc_valid, epc); end
        csr_read(12'h300, d);
        cmp++; if (d !== 32'h0) begin err++; $display("FAIL rst_mstatus got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_csr_fields();
        test_trap_direct();
        test_mret();
        test_trap_vectored();
        test_priority();
        test_mret_irq();
        test_masked_pending();
        test_reset_in_trap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
